// File: rtl/bcd_seg_counter.sv
// Multi-digit BCD up/down counter with programmable prescaler and a scanned 7-segment driver.
// Define BCD_SEG_BLANK_EN to blank leading-zero digits on the display.
module bcd_seg_counter #(
  parameter int          DIGITS    = 4,
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter logic [15:0] SCAN_DIV  = 16'd1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [7:0]            compare_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam logic [2:0]  LAST_IDX  = 3'(DIGITS - 1);
  localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;

  logic [23:0]         presc;
  logic [23:0]         compare;
  logic                step_now;
  logic [4*DIGITS-1:0] count_step;
  logic [4*DIGITS-1:0] load_clean;
  logic                chain;
  logic [3:0]          nib;
  logic [15:0]         scan_cnt;
  logic [2:0]          idx;
  logic [3:0]          disp_nib;
  logic                blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  assign compare  = (compare_in == 8'd0) ? MAX_COUNT : {6'b0, compare_in, 10'b0};
  // ">=" so a compare lowered below the running prescaler wraps on the next edge
  assign step_now = (presc >= compare);

  // Ripple carry/borrow chain; chain left high after the top digit means full wrap
  always_comb begin
    count_step = count;
    load_clean = '0;
    chain      = 1'b1;
    nib        = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib = count[4*k +: 4];
      if (chain) begin
        if (up_dn) begin
          if (nib >= 4'd9) begin
            count_step[4*k +: 4] = 4'd0;
          end else begin
            count_step[4*k +: 4] = nib + 4'd1;
            chain = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            count_step[4*k +: 4] = 4'd9;
          end else begin
            count_step[4*k +: 4] = nib - 4'd1;
            chain = 1'b0;
          end
        end
      end
      load_clean[4*k +: 4] = (load_val[4*k +: 4] > 4'd9) ? 4'd0 : load_val[4*k +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (load) begin
      presc <= '0;
      count <= load_clean;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else if (en) begin
      if (step_now) begin
        presc <= '0;
        count <= count_step;
        tick  <= 1'b1;
        carry <= chain;
      end else begin
        presc <= presc + 24'd1;
        tick  <= 1'b0;
        carry <= 1'b0;
      end
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt >= SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx >= LAST_IDX) ? 3'd0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_comb begin
    disp_nib = '0;
    dig_sel  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == 3'(k)) begin
        disp_nib   = count[4*k +: 4];
        dig_sel[k] = 1'b1;
      end
    end
  end

`ifdef BCD_SEG_BLANK_EN
  logic hz;
  // Walk from the top digit down: a digit blanks when it and everything above it is zero
  always_comb begin
    hz    = 1'b1;
    blank = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hz = hz & (count[4*k +: 4] == 4'd0);
      if ((idx == 3'(k)) && (k != 0)) blank = hz;
    end
  end
`else
  assign blank = 1'b0;
`endif

  assign seg = blank ? 7'h00 : seg_decode(disp_nib);

endmodule

// File: tb/tb_bcd_seg_counter.sv
// Directed bench for bcd_seg_counter: DIGITS=2, MAX_COUNT=4, SCAN_DIV=3.
module tb_bcd_seg_counter;

`ifdef BCD_SEG_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] compare_in = 8'h00;
  logic [7:0] count;
  logic       tick;
  logic       carry;
  logic [6:0] seg;
  logic [1:0] dig_sel;

  bcd_seg_counter #(.DIGITS(2), .MAX_COUNT(24'd4), .SCAN_DIV(16'd3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .compare_in(compare_in), .count(count),
    .tick(tick), .carry(carry), .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mval = 0;
  int mpresc = 0;
  bit mtick = 1'b0;
  bit mcarry = 1'b0;

  typedef struct {
    logic [7:0] lv;
    logic [7:0] cnt;
    logic [6:0] s0;
    logic [6:0] s1;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Behavioural reference for one clock edge, using the inputs currently driven
  task automatic model_edge();
    int cmpv;
    cmpv = (compare_in == 8'd0) ? 4 : int'(compare_in) * 1024;
    if (en) begin
      if (mpresc >= cmpv) begin
        mpresc = 0;
        mtick  = 1'b1;
        if (up_dn) begin
          mval   = (mval + 1) % 100;
          mcarry = (mval == 0);
        end else begin
          mval   = (mval + 99) % 100;
          mcarry = (mval == 99);
        end
      end else begin
        mpresc++;
        mtick  = 1'b0;
        mcarry = 1'b0;
      end
    end else begin
      mtick  = 1'b0;
      mcarry = 1'b0;
    end
  endtask

  task automatic run_model(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check({tag, "_count"}, count, to_bcd(mval));
      check({tag, "_tick"}, tick, mtick);
      check({tag, "_carry"}, carry, mcarry);
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    mpresc = 0;
    mtick = 1'b0;
    mcarry = 1'b0;
  endtask

  task automatic wait_sel(input logic [1:0] target);
    int k;
    k = 0;
    while (dig_sel !== target && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("scan_wait", dig_sel, target);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 7'h3F, 7'h3F};
    vecs[1] = '{8'h07, 8'h07, 7'h07, 7'h3F};
    vecs[2] = '{8'h5C, 8'h50, 7'h3F, 7'h6D};
    vecs[3] = '{8'hC3, 8'h03, 7'h4F, 7'h3F};
    vecs[4] = '{8'h99, 8'h99, 7'h6F, 7'h6F};
    vecs[5] = '{8'h12, 8'h12, 7'h5B, 7'h06};
    vecs[6] = '{8'h84, 8'h84, 7'h66, 7'h7F};
    vecs[7] = '{8'hFF, 8'h00, 7'h3F, 7'h3F};
    vecs[8] = '{8'h36, 8'h36, 7'h7D, 7'h4F};
    vecs[9] = '{8'hA1, 8'h01, 7'h06, 7'h3F};

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_count", count, 8'h00);
    check("rst_tick", tick, 1'b0);
    check("rst_carry", carry, 1'b0);
    check("rst_dig_sel", dig_sel, 2'b01);
    check("rst_seg", seg, 7'h3F);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Count up from reset through the 99 -> 00 wrap
    mval = 0;
    mpresc = 0;
    en = 1'b1;
    up_dn = 1'b1;
    compare_in = 8'h00;
    run_model(505, "up");

    // Down count from 00: 99 with carry, then 98 without
    do_load(8'h00);
    mval = 0;
    check("load00_count", count, 8'h00);
    up_dn = 1'b0;
    run_model(5, "down");
    check("down_99", count, 8'h99);
    check("down_99_carry", carry, 1'b1);
    run_model(5, "down");
    check("down_98", count, 8'h98);
    check("down_98_carry", carry, 1'b0);

    // Load colliding with a tick edge wins and restarts the prescaler
    up_dn = 1'b1;
    for (int k = 0; k < 10 && mpresc != 4; k++) run_model(1, "align");
    check("align_presc", mpresc, 4);
    do_load(8'h5C);
    mval = 50;
    check("loadtick_count", count, 8'h50);
    check("loadtick_tick", tick, 1'b0);
    check("loadtick_carry", carry, 1'b0);
    run_model(5, "after_load");
    check("after_load_51", count, 8'h51);
    check("after_load_tick", tick, 1'b1);

    // compare_in = 1 gives a 1025-clock period; lowering compare mid-period wraps at once
    compare_in = 8'h01;
    do_load(8'h00);
    mval = 0;
    run_model(1025, "cmp1024");
    check("cmp1024_tick", tick, 1'b1);
    check("cmp1024_count", count, 8'h01);
    run_model(600, "cmp_mid");
    compare_in = 8'h00;
    run_model(1, "cmp_drop");
    check("cmp_drop_tick", tick, 1'b1);
    check("cmp_drop_count", count, 8'h02);
    run_model(10, "cmp4");
    check("cmp4_count", count, 8'h04);

    // Table: load/sanitise and per-digit decode with the counter held
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      logic [6:0] e1;
      do_load(vecs[i].lv);
      check("tbl_count", count, vecs[i].cnt);
      check("tbl_tick", tick, 1'b0);
      e1 = (BLANK && vecs[i].cnt[7:4] == 4'd0) ? 7'h00 : vecs[i].s1;
      wait_sel(2'b01);
      check("tbl_seg0", seg, vecs[i].s0);
      wait_sel(2'b10);
      check("tbl_seg1", seg, e1);
    end

    // Scan timing: each digit held for exactly 3 clocks
    do_load(8'h07);
    wait_sel(2'b10);
    wait_sel(2'b01);
    for (int i = 0; i < 12; i++) begin
      if (((i / 3) % 2) == 0) begin
        check("scan_sel_lo", dig_sel, 2'b01);
        check("scan_seg_lo", seg, 7'h07);
      end else begin
        check("scan_sel_hi", dig_sel, 2'b10);
        check("scan_seg_hi", seg, BLANK ? 7'h00 : 7'h3F);
      end
      check("scan_hold_count", count, 8'h07);
      check("scan_hold_tick", tick, 1'b0);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset mid-period
    en = 1'b1;
    up_dn = 1'b1;
    compare_in = 8'h00;
    do_load(8'h42);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_count", count, 8'h42);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count, 8'h00);
    check("arst_tick", tick, 1'b0);
    check("arst_carry", carry, 1'b0);
    check("arst_dig_sel", dig_sel, 2'b01);
    check("arst_seg", seg, 7'h3F);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mval = 0;
    mpresc = 0;
    run_model(5, "post_rst");
    check("post_rst_count", count, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_counter.md
# bcd_seg_counter

Parametrised multi-digit decimal counter with a programmable prescaler and a time-multiplexed 7-segment driver. Successor to the single-digit second counter: DIGITS-wide BCD value, up/down counting, synchronous preload, cascade carry, and digit scanning so one segment bus drives DIGITS displays. Sits between the top-level pins (switches in, segment/digit-select out) and replaces the single-digit counter plus decoder pair.

## Interface
- DIGITS, 4: number of BCD digits, 1..8
- MAX_COUNT, 24'd10_000_000: prescaler terminal value used when compare_in == 0
- SCAN_DIV, 16'd1000: clocks per digit slot in the display scan, >= 1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  count enable; prescaler and counter hold when 0
- up_dn  in  1  1 = count up, 0 = count down
- load  in  1  synchronous preload strobe
- load_val  in  4*DIGITS  preload value, digit 0 in bits [3:0]
- compare_in  in  8  prescaler override; 0 selects MAX_COUNT, else {6'b0, compare_in, 10'b0}
- count  out  4*DIGITS  current BCD value
- tick  out  1  one-cycle pulse on every prescaler terminal
- carry  out  1  one-cycle pulse when the full value wraps (all-9 -> 0 up, 0 -> all-9 down)
- seg  out  7  segments {g,f,e,d,c,b,a}, active high
- dig_sel  out  DIGITS  one-hot digit enable, active high, bit 0 = least-significant digit

## Operation
- Prescaler: 24-bit presc counts up while en = 1. On an edge where presc >= compare: presc <= 0, tick <= 1, counter steps. Otherwise presc + 1, tick <= 0. ">=" ensures a compare lowered below presc wraps on the next edge.
- Counter step: up increments digit 0 and ripples carries through 9 -> 0; down decrements with borrows 0 -> 9. carry <= 1 only on full-value wrap in the step edge.
- load = 1 (any en): count <= load_val, presc <= 0, tick <= 0, carry <= 0. load wins over a simultaneous step. Any load nibble > 9 loads as 0.
- en = 0: presc, count held; tick and carry 0 the next cycle.
- up_dn is sampled only on step edges; changing it mid-period is legal.
- Scan: scan counter 0..SCAN_DIV-1 runs continuously (independent of en). On wrap, digit index advances 0 -> 1 -> ... -> DIGITS-1 -> 0.
- dig_sel = one-hot(index); seg = decode(count nibble[index]). Decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F (hex, {g..a}).
- Counter has no FSM beyond the carry chain; scanning is a DIGITS-state ring.

## Timing
- Reset (async assert, sync to clk on release): presc = 0, count = 0, tick = 0, carry = 0, scan = 0, index = 0, dig_sel = 1, seg = 7'h3F.
- tick period = compare + 1 clocks with en held high; count and tick update on the same edge.
- count, tick, carry registered; seg and dig_sel combinational from registered count/index, zero added latency.
- Each digit is displayed for exactly SCAN_DIV clocks; full refresh = DIGITS*SCAN_DIV clocks.
- Reset asserted mid-period aborts immediately; no partial step survives.

## Configuration
- BCD_SEG_BLANK_EN defined: leading-zero blanking. Digit k (k >= 1) shows seg = 0 when its nibble and all higher nibbles are 0. Digit 0 is never blanked. dig_sel unchanged.
- Undefined: every digit always shows its decoded value, including leading zeros.

## Test plan
Use DIGITS=2, MAX_COUNT=4, SCAN_DIV=3 unless noted.
- Reset, en=1, up_dn=1, compare_in=0 -> tick every 5 clocks; count 00 -> 01 -> ... -> 99 -> 00 with carry pulsed exactly on the 99 -> 00 edge.
- load_val=8'h00, load, then up_dn=0 -> first step gives 99 with carry=1; next step 98, carry=0.
- load_val=8'h5C with load coinciding with a tick edge -> count = 8'h50, presc = 0, no step, tick=0 that cycle.
- compare_in=1 -> period 1025 clocks; switch compare_in to 0 when presc = 600 -> wrap on next edge (600 >= 4), period 5 thereafter.
- count=8'h07 held (en=0) -> dig_sel 01 for 3 clocks with seg 7'h07, then 10 for 3 clocks with seg 7'h3F (7'h00 with BCD_SEG_BLANK_EN), repeating.
- Assert rst_n=0 asynchronously mid-period with count=8'h42 -> all outputs at reset values before next clk edge.
